// File: rtl/blink_detect.sv
// Measures edge-to-edge intervals of an asynchronous toggling input and reports
// whether it is toggling at the expected rate (lock), with loss-of-signal detection.
module blink_detect #(
    parameter int unsigned HALF_PERIOD = 33,
    parameter int unsigned TOL         = 2,
    parameter int unsigned LOCK_N      = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        blink_in,
    output logic [15:0] half_period,
    output logic        period_valid,
    output logic        match,
    output logic        locked,
    output logic        timeout,
    output logic [7:0]  Led
);

    localparam logic [16:0] MeasLo  = 17'(HALF_PERIOD - TOL);
    localparam logic [16:0] MeasHi  = 17'(HALF_PERIOD + TOL);
    localparam logic [15:0] CntMax  = 16'(TIMEOUT);
    localparam logic [2:0]  LockCnt = 3'(LOCK_N);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StArmed  = 2'd1,
        StLocked = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        s1_q, s2_q, s3_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  mcnt_q, mcnt_d;
    logic [15:0] hp_q, hp_d;
    logic        pv_q, pv_d;
    logic        match_q, match_d;
    logic        to_q, to_d;

    logic        edge_det;
    logic [16:0] meas;
    logic        in_tol;
    logic [2:0]  mcnt_inc;

    assign edge_det = s2_q ^ s3_q;
    // cnt never exceeds TIMEOUT, so the 17-bit sum cannot overflow.
    assign meas     = {1'b0, cnt_q} + 17'd1;
    assign in_tol   = (meas >= MeasLo) && (meas <= MeasHi);
    assign mcnt_inc = (mcnt_q >= LockCnt) ? LockCnt : mcnt_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcnt_d  = mcnt_q;
        hp_d    = hp_q;
        pv_d    = 1'b0;
        match_d = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (edge_det) begin
                    state_d = StArmed;
                    mcnt_d  = '0;
                end
            end
            StArmed, StLocked: begin
                // An edge wins over a simultaneous timeout.
                if (edge_det) begin
                    cnt_d   = '0;
                    hp_d    = meas[15:0];
                    pv_d    = 1'b1;
                    match_d = in_tol;
                    if (in_tol) begin
                        mcnt_d  = mcnt_inc;
                        state_d = (mcnt_inc == LockCnt) ? StLocked : StArmed;
                    end else begin
                        mcnt_d  = '0;
                        state_d = StArmed;
                    end
                end else if (cnt_q == CntMax) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    mcnt_d  = '0;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                mcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            cnt_q   <= '0;
            mcnt_q  <= '0;
            hp_q    <= '0;
            pv_q    <= 1'b0;
            match_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= blink_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            cnt_q   <= cnt_d;
            mcnt_q  <= mcnt_d;
            hp_q    <= hp_d;
            pv_q    <= pv_d;
            match_q <= match_d;
            to_q    <= to_d;
        end
    end

    assign half_period  = hp_q;
    assign period_valid = pv_q;
    assign match        = match_q;
    assign timeout      = to_q;
    assign locked       = (state_q == StLocked);
    assign Led          = {6'b0, s2_q, locked};

endmodule

// File: tb/tb_blink_detect.sv
// Randomized scoreboard bench for blink_detect: a reference model works on
// input-sample timestamps and queues expected measurement/timeout events.
module tb_blink_detect;

    localparam int unsigned HP   = 33;
    localparam int unsigned TOL  = 2;
    localparam int unsigned LOCKN = 4;
    localparam int unsigned TMO  = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        blink_in = 1'b0;
    logic [15:0] half_period;
    logic        period_valid;
    logic        match;
    logic        locked;
    logic        timeout;
    logic [7:0]  Led;

    always #5 clk = ~clk;

    blink_detect #(
        .HALF_PERIOD(HP),
        .TOL        (TOL),
        .LOCK_N     (LOCKN),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .blink_in    (blink_in),
        .half_period (half_period),
        .period_valid(period_valid),
        .match       (match),
        .locked      (locked),
        .timeout     (timeout),
        .Led         (Led)
    );

    typedef struct {
        int unsigned cyc;
        bit          is_to;
        int unsigned hp;
        bit          m;
        bit          lk;
    } exp_t;

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int unsigned cyc    = 0;

    // Reference model state: timestamps are posedge indices at which a new
    // input level was first sampled.
    bit          prev_smp;
    bit          armed;
    int unsigned last_t;
    int unsigned mcount;
    bit          m_locked;
    int unsigned last_hp;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_smp = 1'b0;
            armed    = 1'b0;
            mcount   = 0;
            m_locked = 1'b0;
            last_hp  = 0;
            q.delete();
        end else begin
            exp_t        e;
            int unsigned d;
            bit          ok;
            cyc++;
            if (blink_in != prev_smp) begin
                prev_smp = blink_in;
                if (!armed) begin
                    armed  = 1'b1;
                    mcount = 0;
                end else begin
                    d  = cyc - last_t;
                    ok = (d >= HP - TOL) && (d <= HP + TOL);
                    mcount   = ok ? ((mcount + 1 > LOCKN) ? LOCKN : mcount + 1) : 0;
                    m_locked = (mcount == LOCKN);
                    last_hp  = d;
                    e.cyc = cyc + 2; e.is_to = 1'b0; e.hp = d; e.m = ok; e.lk = m_locked;
                    q.push_back(e);
                end
                last_t = cyc;
            end else if (armed && (cyc - last_t == TMO + 1)) begin
                armed    = 1'b0;
                mcount   = 0;
                m_locked = 1'b0;
                e.cyc = cyc + 2; e.is_to = 1'b1; e.hp = last_hp; e.m = 1'b0; e.lk = 1'b0;
                q.push_back(e);
            end
        end
    end

    // Monitor: compares DUT output events against the queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (period_valid || timeout) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_kind_timeout", timeout, e.is_to);
                    chk("event_kind_valid", period_valid, !e.is_to);
                    chk("half_period", half_period, e.hp);
                    chk("match", match, e.m);
                    chk("locked", locked, e.lk);
                    chk("led0_locked", Led[0], locked);
                    chk("led_upper", Led[7:2], 0);
                end
            end else begin
                if (match) chk("match_without_valid", match, 0);
                if (q.size() > 0 && q[0].cyc < cyc) begin
                    chk("missing_event_at", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle_run(input int k, input int n);
        repeat (n) begin
            wait_clk(k);
            blink_in = ~blink_in;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_half_period", half_period, 0);
        chk("rst_period_valid", period_valid, 0);
        chk("rst_match", match, 0);
        chk("rst_locked", locked, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_led", Led, 0);
    endtask

    task automatic pulse_reset(input bit level_at_release);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        wait_clk(3);
        blink_in = level_at_release;
        rst_n    = 1'b1;
    endtask

    initial begin
        wait_clk(3);
        check_reset_outputs();
        rst_n = 1'b1;

        // Nominal rate locks; edge rate at the tolerance limit keeps lock.
        toggle_run(HP, 8);
        wait_clk(4);
        chk("locked_after_33", locked, 1);
        toggle_run(HP + TOL, 6);
        wait_clk(4);
        chk("locked_after_35", locked, 1);
        toggle_run(HP + TOL + 1, 6);
        wait_clk(4);
        chk("unlocked_after_36", locked, 0);

        // Single long interval breaks lock, then relock.
        toggle_run(HP, 6);
        toggle_run(40, 1);
        toggle_run(HP, 5);
        wait_clk(4);
        chk("relocked_after_40", locked, 1);

        // Loss of signal.
        wait_clk(300);
        chk("unlocked_after_timeout", locked, 0);
        toggle_run(HP, 8);

        // One-clock glitch while locked.
        wait_clk(HP);
        blink_in = ~blink_in;
        wait_clk(1);
        blink_in = ~blink_in;
        toggle_run(HP, 6);

        // Edge exactly at the timeout boundary, then one cycle past it.
        toggle_run(TMO + 1, 1);
        toggle_run(HP, 6);
        toggle_run(TMO + 2, 1);
        toggle_run(HP, 6);

        // Random intervals, mostly near nominal.
        repeat (60) begin
            int k;
            if ($urandom_range(0, 7) == 0) k = $urandom_range(1, 300);
            else k = $urandom_range(HP - TOL - 2, HP + TOL + 2);
            toggle_run(k, 1);
        end

        // Reset while locked and mid-measurement, release with input high.
        toggle_run(HP, 6);
        wait_clk(15);
        pulse_reset(1'b1);
        toggle_run(HP, 6);
        wait_clk(4);
        chk("relocked_after_reset", locked, 1);

        wait_clk(300);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/blink_detect.md
BLINK_DETECT -- requirements
Module: blink_detect

Interface
REQ-001 Parameter HALF_PERIOD, default 33: expected clock cycles between consecutive input edges.
REQ-002 Parameter TOL, default 2: allowed absolute deviation from HALF_PERIOD; constraint 0 <= TOL < HALF_PERIOD.
REQ-003 Parameter LOCK_N, default 4: consecutive in-tolerance measurements required for lock; constraint 1..7.
REQ-004 Parameter TIMEOUT, default 255: edge-free cycles before loss of signal; constraint HALF_PERIOD+TOL < TIMEOUT < 65535.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 blink_in  input  1  asynchronous toggling signal under measurement (e.g. a blinking LED line).
REQ-008 half_period  output  16  last measured edge-to-edge interval in clk cycles; holds between measurements.
REQ-009 period_valid  output  1  one-cycle pulse when half_period is updated.
REQ-010 match  output  1  qualifies period_valid: 1 when the new measurement is within tolerance; 0 when period_valid is 0.
REQ-011 locked  output  1  level; input is toggling at the expected rate.
REQ-012 timeout  output  1  one-cycle pulse on loss of signal.
REQ-013 Led  output  8  board LEDs: Led[0]=locked, Led[1]=synchronized input level, Led[7:2]=0.

Function
REQ-014 blink_in passes through a 2-flop synchronizer (s1, s2); a third flop s3 holds the previous s2; edge = s2 XOR s3.
REQ-015 Either input transition direction counts as an edge.
REQ-016 Interval counter cnt, 16 bits: cleared to 0 the cycle after an edge, otherwise increments by 1; it is never allowed to wrap (see REQ-021).
REQ-017 FSM states: IDLE (no reference edge), ARMED (measuring, not locked), LOCKED.
REQ-018 IDLE: on edge -> ARMED, cnt cleared, no period_valid, match count cleared.
REQ-019 ARMED/LOCKED, on edge: half_period <= cnt+1; period_valid=1 and match registered the following cycle; in-tolerance means HALF_PERIOD-TOL <= cnt+1 <= HALF_PERIOD+TOL, compared unsigned with no wrap.
REQ-020 Match counter: in-tolerance increments (saturates at LOCK_N); out-of-tolerance clears to 0. ARMED -> LOCKED when count reaches LOCK_N; LOCKED -> ARMED on any out-of-tolerance measurement.
REQ-021 ARMED/LOCKED with no edge and cnt == TIMEOUT: -> IDLE, timeout pulse next cycle, match count cleared; half_period holds its value.
REQ-022 Simultaneous edge and cnt == TIMEOUT: the edge has priority (measurement TIMEOUT+1, out of tolerance, ARMED); no timeout pulse.
REQ-023 locked = (state == LOCKED), registered; it changes in the same cycle that the causing period_valid or timeout pulse asserts.
REQ-024 Latency: an input transition produces edge 2-3 clk later; period_valid follows edge by exactly 1 clk.
REQ-025 IDLE: cnt held at 0; timeout never asserts.

Reset
REQ-026 rst_n low immediately forces: state IDLE; s1, s2, s3, cnt, match count = 0; half_period = 0; period_valid, match, locked, timeout = 0; Led = 0.
REQ-027 Operation resumes on the first rising clk edge after rst_n deasserts; a high blink_in at release produces one edge (first reference edge), with no measurement.
REQ-028 Reset asserted mid-measurement discards the measurement in progress; no pulse is emitted.

Verification
REQ-029 blink_in toggles every 33 clk -> half_period=33, match=1 on every period_valid from the 2nd edge; locked rises with the 4th period_valid (5th edge).
REQ-030 Toggle every 35 clk -> match=1, lock after 4 measurements; toggle every 36 clk -> match=0, locked stays 0.
REQ-031 Locked, then one interval of 40 clk -> period_valid with half_period=40, match=0, locked=0 in that cycle; 4 further 33-clk intervals relock.
REQ-032 Locked, then blink_in held constant -> timeout pulse 257 clk after the last edge (TIMEOUT=255), locked=0; next edge gives no period_valid; the following edge gives one.
REQ-033 One-cycle-wide 1-clk pulse on blink_in while locked -> measurement of 1 clk, match=0, locked=0.
REQ-034 rst_n pulsed low while locked -> all outputs 0 with no clock edge needed; 33-clk toggling afterwards relocks per REQ-029.
